// File: rtl/acc_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_cmd_if
// Function : CPU-facing command/configuration interface for an accelerator.
//            Decodes a small register map, sequences the three-word
//            configuration load, supervises the run with a timeout counter,
//            and arbitrates the shared data memory port between the CPU and
//            the accelerator.
// Revision : 1.0 - initial release
// ============================================================================
module acc_cmd_if #(
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  // CPU data port
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic        cpu_re_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  // Accelerator control
  output logic        acc_enable_o,
  output logic [31:0] acc_addr_o,
  output logic [31:0] acc_data_o,
  input  logic        acc_done_i,
  // Accelerator memory request
  input  logic [13:0] acc_mem_addr_i,
  input  logic        acc_wenb_i,
  input  logic        acc_renb_i,
  input  logic [3:0]  acc_webb_i,
  input  logic [31:0] acc_wdata_i,
  // Shared data memory port
  output logic [13:0] dmem_addr_o,
  output logic [3:0]  dmem_webb_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  // Completion interrupt
  output logic        irq_o
);

  localparam logic [31:0] c_ADDR_CFG0   = 32'h0008_0000;
  localparam logic [31:0] c_ADDR_CFG1   = 32'h000C_0000;
  localparam logic [31:0] c_ADDR_CMD    = 32'h0010_0000;
  localparam logic [31:0] c_ADDR_STATUS = 32'h0014_0000;
  localparam logic [31:0] c_START_WORD  = 32'h0000_0001;
  localparam logic [15:0] c_CNT_LAST    = TIMEOUT_CYC - 16'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD0 = 3'd1,
    S_LOAD1 = 3'd2,
    S_LOAD2 = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cfg0_q, cfg0_d;
  logic [31:0] cfg1_q, cfg1_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        err_q, err_d;

  logic        w_hit_cfg0, w_hit_cfg1, w_hit_cmd, w_hit_status, w_hit_map;
  logic        w_dmem_tgt, w_busy;
  logic        w_wr_cfg0, w_wr_cfg1, w_wr_cmd;
  logic        w_cmd_start, w_cmd_clear, w_cmd_abort;
  logic        w_err_evt;
  logic [31:0] w_status;
  logic        w_unused;

  // The read-enable from the accelerator carries no information for this
  // port: reads are implied by the address being presented.
  assign w_unused = acc_renb_i;

  // Full 32-bit decode; every other address belongs to the data memory.
  assign w_hit_cfg0   = (cpu_addr_i == c_ADDR_CFG0);
  assign w_hit_cfg1   = (cpu_addr_i == c_ADDR_CFG1);
  assign w_hit_cmd    = (cpu_addr_i == c_ADDR_CMD);
  assign w_hit_status = (cpu_addr_i == c_ADDR_STATUS);
  assign w_hit_map    = w_hit_cfg0 | w_hit_cfg1 | w_hit_cmd | w_hit_status;
  assign w_dmem_tgt   = (cpu_we_i | cpu_re_i) & ~w_hit_map;

  assign w_busy = (state_q == S_LOAD0) | (state_q == S_LOAD1) |
                  (state_q == S_LOAD2) | (state_q == S_RUN);

  assign w_wr_cfg0   = cpu_we_i & w_hit_cfg0;
  assign w_wr_cfg1   = cpu_we_i & w_hit_cfg1;
  assign w_wr_cmd    = cpu_we_i & w_hit_cmd;
  assign w_cmd_start = w_wr_cmd & cpu_wdata_i[0];
  assign w_cmd_clear = w_wr_cmd & cpu_wdata_i[1];
  assign w_cmd_abort = w_wr_cmd & cpu_wdata_i[2];

  // Configuration or start attempts outside IDLE are flagged; a start bit
  // riding along with a clear in DONE is silently dropped, not an error.
  assign w_err_evt = (state_q != S_IDLE) &
                     (w_wr_cfg0 | w_wr_cfg1 |
                      (w_cmd_start & ~((state_q == S_DONE) & w_cmd_clear)));

  assign w_status = {28'd0, err_q, timeout_q, done_q, w_busy};

  // State, configuration, counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cfg0_q    <= 32'd0;
      cfg1_q    <= 32'd0;
      cnt_q     <= 16'd0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg0_q    <= cfg0_d;
      cfg1_q    <= cfg1_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: sequencing, config latching, run supervision, status.
  always_comb begin
    state_d   = state_q;
    cfg0_d    = cfg0_q;
    cfg1_d    = cfg1_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    err_d     = err_q;

    if (w_err_evt) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_wr_cfg0) begin
          cfg0_d = cpu_wdata_i;
        end
        if (w_wr_cfg1) begin
          cfg1_d = cpu_wdata_i;
        end
        if (w_cmd_clear) begin
          err_d = 1'b0;
        end
        if (w_cmd_start) begin
          state_d = S_LOAD0;
        end
      end
      S_LOAD0: state_d = S_LOAD1;
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: begin
        // Counter starts from zero on the first RUN cycle.
        cnt_d   = 16'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (acc_done_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (w_cmd_abort) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (w_cmd_clear) begin
          state_d   = S_IDLE;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accelerator-facing outputs decoded from the current state.
  always_comb begin
    acc_enable_o = 1'b0;
    acc_addr_o   = 32'd0;
    acc_data_o   = 32'd0;
    irq_o        = 1'b0;
    case (state_q)
      S_LOAD0: begin
        acc_enable_o = 1'b1;
        acc_addr_o   = c_ADDR_CFG0;
        acc_data_o   = cfg0_q;
      end
      S_LOAD1: begin
        acc_enable_o = 1'b1;
        acc_addr_o   = c_ADDR_CFG1;
        acc_data_o   = cfg1_q;
      end
      S_LOAD2: begin
        acc_enable_o = 1'b1;
        acc_addr_o   = c_ADDR_CMD;
        acc_data_o   = c_START_WORD;
      end
      S_RUN:   acc_enable_o = 1'b1;
      S_DONE:  irq_o        = 1'b1;
      default: acc_enable_o = 1'b0;
    endcase
  end

  // CPU stall, data memory arbitration and CPU read-data mux.
  always_comb begin
    cpu_stall_o = w_busy & w_dmem_tgt;

    if (state_q == S_RUN) begin
      dmem_addr_o  = acc_mem_addr_i;
      dmem_webb_o  = acc_wenb_i ? acc_webb_i : 4'h0;
      dmem_wdata_o = acc_wdata_i;
    end else begin
      // Register-map stores and stalled stores never reach the memory.
      dmem_addr_o  = cpu_addr_i[15:2];
      dmem_webb_o  = (cpu_we_i & w_dmem_tgt & ~cpu_stall_o) ? 4'hF : 4'h0;
      dmem_wdata_o = cpu_wdata_i;
    end

    if (w_hit_cfg0) begin
      cpu_rdata_o = cfg0_q;
    end else if (w_hit_cfg1) begin
      cpu_rdata_o = cfg1_q;
    end else if (w_hit_status) begin
      cpu_rdata_o = w_status;
    end else if (w_hit_cmd) begin
      cpu_rdata_o = 32'd0;
    end else begin
      cpu_rdata_o = dmem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_cmd_if
// Function : Self-checking bench for acc_cmd_if (default timeout instance
//            plus a short-timeout instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cmd_if;

  localparam logic [31:0] c_CFG0   = 32'h0008_0000;
  localparam logic [31:0] c_CFG1   = 32'h000C_0000;
  localparam logic [31:0] c_CMD    = 32'h0010_0000;
  localparam logic [31:0] c_STATUS = 32'h0014_0000;
  localparam logic [31:0] c_MEMRD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic        acc_done = 1'b0;
  logic [13:0] acc_mem_addr = 14'h0007;
  logic        acc_wenb = 1'b1;
  logic        acc_renb = 1'b0;
  logic [3:0]  acc_webb = 4'h3;
  logic [31:0] acc_wdata = 32'h1234_5678;
  logic [31:0] dmem_rdata = c_MEMRD;

  logic [31:0] rdata, aaddr, adata, dwdata;
  logic        stall, en, irq;
  logic [13:0] daddr;
  logic [3:0]  webb;

  logic [31:0] t_rdata, t_aaddr, t_adata, t_dwdata;
  logic        t_stall, t_en, t_irq;
  logic [13:0] t_daddr;
  logic [3:0]  t_webb;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  acc_cmd_if dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_we_i(cpu_we), .cpu_re_i(cpu_re),
    .cpu_rdata_o(rdata), .cpu_stall_o(stall),
    .acc_enable_o(en), .acc_addr_o(aaddr), .acc_data_o(adata), .acc_done_i(acc_done),
    .acc_mem_addr_i(acc_mem_addr), .acc_wenb_i(acc_wenb), .acc_renb_i(acc_renb),
    .acc_webb_i(acc_webb), .acc_wdata_i(acc_wdata),
    .dmem_addr_o(daddr), .dmem_webb_o(webb), .dmem_wdata_o(dwdata), .dmem_rdata_i(dmem_rdata),
    .irq_o(irq)
  );

  acc_cmd_if #(.TIMEOUT_CYC(16'd8)) dut_to (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_we_i(cpu_we), .cpu_re_i(cpu_re),
    .cpu_rdata_o(t_rdata), .cpu_stall_o(t_stall),
    .acc_enable_o(t_en), .acc_addr_o(t_aaddr), .acc_data_o(t_adata), .acc_done_i(acc_done),
    .acc_mem_addr_i(acc_mem_addr), .acc_wenb_i(acc_wenb), .acc_renb_i(acc_renb),
    .acc_webb_i(acc_webb), .acc_wdata_i(acc_wdata),
    .dmem_addr_o(t_daddr), .dmem_webb_o(t_webb), .dmem_wdata_o(t_dwdata), .dmem_rdata_i(dmem_rdata),
    .irq_o(t_irq)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] x_rdata;
    logic        x_stall;
    logic        x_en;
    logic [31:0] x_aaddr;
    logic [31:0] x_adata;
    logic        x_irq;
    logic [13:0] x_daddr;
    logic [3:0]  x_webb;
    logic [31:0] x_dwdata;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic done);
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    acc_done  = done;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle STATUS read on the default instance.
  task automatic rd_status(input string name, input logic [31:0] exp);
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk(name, rdata, exp);
    next_cyc();
  endtask

  // CMD start write followed by the three LOAD cycles; returns in first RUN cycle.
  task automatic start_run();
    drive(1'b1, 1'b0, c_CMD, 32'h1, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next_cyc();
    next_cyc();
    next_cyc();
  endtask

  initial begin
    int run_cnt;
    logic seen;

    //           we   re   addr          wdata  done  rdata    stall en  aaddr       adata  irq daddr  webb  dwdata
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'hA5, 1'b0, c_MEMRD, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h10, 4'hF, 32'hA5};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,  1'b0, c_MEMRD, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h40, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, c_CFG0,        32'h10, 1'b0, 32'h0,   1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h0,  4'h0, 32'h10};
    tbl[3]  = '{1'b1, 1'b0, c_CFG1,        32'h40, 1'b0, 32'h0,   1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h0,  4'h0, 32'h40};
    tbl[4]  = '{1'b0, 1'b1, c_CFG0,        32'h0,  1'b0, 32'h10,  1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h0,  4'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, c_CFG1,        32'h0,  1'b0, 32'h40,  1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h0,  4'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, c_CMD,         32'h1,  1'b0, 32'h0,   1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 14'h0,  4'h0, 32'h1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b0, c_MEMRD, 1'b0, 1'b1, c_CFG0, 32'h10, 1'b0, 14'h0, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, c_STATUS,      32'h0,  1'b0, 32'h1,   1'b0, 1'b1, c_CFG1, 32'h40, 1'b0, 14'h0, 4'h0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b0, c_MEMRD, 1'b0, 1'b1, c_CMD,  32'h1,  1'b0, 14'h0, 4'h0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, c_STATUS,      32'h0,  1'b0, 32'h1,   1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 14'h7,  4'h3, 32'h1234_5678};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,  1'b0, c_MEMRD, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 14'h7,  4'h3, 32'h1234_5678};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0100, 32'h99, 1'b0, c_MEMRD, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 14'h7,  4'h3, 32'h1234_5678};

    // Reset
    rst = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("rst_status", rdata, 32'h0);
    chk("rst_en", {31'd0, en}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_aaddr", aaddr, 32'h0);
    chk("rst_adata", adata, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    next_cyc();

    // Table: config, load sequence, first RUN cycles
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].done);
      #4;
      chk($sformatf("row%0d_rdata", i), rdata, tbl[i].x_rdata);
      chk($sformatf("row%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].x_stall});
      chk($sformatf("row%0d_en", i), {31'd0, en}, {31'd0, tbl[i].x_en});
      chk($sformatf("row%0d_aaddr", i), aaddr, tbl[i].x_aaddr);
      chk($sformatf("row%0d_adata", i), adata, tbl[i].x_adata);
      chk($sformatf("row%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].x_irq});
      chk($sformatf("row%0d_daddr", i), {18'd0, daddr}, {18'd0, tbl[i].x_daddr});
      chk($sformatf("row%0d_webb", i), {28'd0, webb}, {28'd0, tbl[i].x_webb});
      chk($sformatf("row%0d_dwdata", i), dwdata, tbl[i].x_dwdata);
      next_cyc();
    end

    // RUN cycles 4..20 with a pending CPU load: stall held throughout
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0100, 32'd0, 1'b0);
      #4;
      chk($sformatf("run_stall%0d", i), {31'd0, stall}, 32'h1);
      next_cyc();
    end
    // Completion pulse on RUN cycle 21
    drive(1'b0, 1'b1, 32'h0000_0100, 32'd0, 1'b1);
    #4;
    chk("done_cyc_stall", {31'd0, stall}, 32'h1);
    next_cyc();
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("done_status", rdata, 32'h2);
    chk("done_irq", {31'd0, irq}, 32'h1);
    chk("done_en", {31'd0, en}, 32'h0);
    next_cyc();
    drive(1'b0, 1'b1, 32'h0000_0100, 32'd0, 1'b0);
    #4;
    chk("done_nostall", {31'd0, stall}, 32'h0);
    chk("done_memrd", rdata, c_MEMRD);
    next_cyc();
    // Clear together with start: start is dropped
    drive(1'b1, 1'b0, c_CMD, 32'h3, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #4;
    chk("clr_start_en", {31'd0, en}, 32'h0);
    chk("clr_start_irq", {31'd0, irq}, 32'h0);
    next_cyc();
    rd_status("clr_start_status", 32'h0);

    // acc_done and abort in the same RUN cycle: completion wins
    start_run();
    next_cyc();
    drive(1'b1, 1'b0, c_CMD, 32'h4, 1'b1);
    next_cyc();
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("prio_status", rdata, 32'h2);
    chk("prio_irq", {31'd0, irq}, 32'h1);
    next_cyc();
    drive(1'b1, 1'b0, c_CMD, 32'h2, 1'b0);
    next_cyc();
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("clear_status", rdata, 32'h0);
    chk("clear_irq", {31'd0, irq}, 32'h0);
    next_cyc();

    // Plain abort returns to IDLE without done
    start_run();
    drive(1'b1, 1'b0, c_CMD, 32'h4, 1'b0);
    next_cyc();
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("abort_status", rdata, 32'h0);
    chk("abort_en", {31'd0, en}, 32'h0);
    chk("abort_irq", {31'd0, irq}, 32'h0);
    next_cyc();
    // acc_done outside RUN is ignored
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    next_cyc();
    rd_status("idle_done_status", 32'h0);

    // CFG0 write during RUN is dropped and flags err; reset aborts the run
    start_run();
    drive(1'b1, 1'b0, c_CFG0, 32'h55, 1'b0);
    next_cyc();
    drive(1'b0, 1'b1, c_CFG0, 32'd0, 1'b0);
    #4;
    chk("run_cfg0_kept", rdata, 32'h10);
    chk("run_cfg0_en", {31'd0, en}, 32'h1);
    next_cyc();
    rd_status("run_err_status", 32'h9);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next_cyc();
    rst = 1'b0;
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("rstrun_status", rdata, 32'h0);
    chk("rstrun_en", {31'd0, en}, 32'h0);
    next_cyc();

    // Timeout on the short-timeout instance
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    drive(1'b1, 1'b0, c_CMD, 32'h1, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    run_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (t_irq) begin
        seen = 1'b1;
        break;
      end
      if (t_en && (t_aaddr == 32'd0)) run_cnt++;
      next_cyc();
    end
    chk("to_reached", {31'd0, seen}, 32'h1);
    chk("to_run_cycles", run_cnt, 32'd8);
    next_cyc();
    drive(1'b0, 1'b1, c_STATUS, 32'd0, 1'b0);
    #4;
    chk("to_status", t_rdata, 32'h6);
    chk("to_irq", {31'd0, t_irq}, 32'h1);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
